// File: rtl/alu_share_arbiter.sv
// Purpose: round-robin share of one combinational ALU between NUM_REQ requesters,
//          with a registered issue stage and a registered response stage.
// Latency: transfer at edge k -> operands on ALU in cycle k+1 -> rsp_valid from cycle k+2.
// Backpressure: rsp_ready low holds the response; the issue stage fills once, then req_ready=0.
//
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   req_valid/req_ready     per-requester request handshake (ready is one-hot or zero)
//   req_op/req_a/req_b      packed per-requester opcode (4b) and operands (32b each)
//   alu_op/alu_a/alu_b      issue register to the shared ALU (0 when the issue stage is empty)
//   alu_result              combinational ALU result
//   rsp_valid/rsp_ready     per-requester response handshake (valid is one-hot or zero)
//   rsp_data/rsp_err        shared response payload; rsp_err flags opcodes 4'b1011..4'b1111
//   busy                    issue or response stage occupied
module alu_share_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int ID_W    = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NUM_REQ-1:0]    req_valid,
  output logic [NUM_REQ-1:0]    req_ready,
  input  logic [4*NUM_REQ-1:0]  req_op,
  input  logic [32*NUM_REQ-1:0] req_a,
  input  logic [32*NUM_REQ-1:0] req_b,
  output logic [3:0]            alu_op,
  output logic [31:0]           alu_a,
  output logic [31:0]           alu_b,
  input  logic [31:0]           alu_result,
  output logic [NUM_REQ-1:0]    rsp_valid,
  input  logic [NUM_REQ-1:0]    rsp_ready,
  output logic [31:0]           rsp_data,
  output logic                  rsp_err,
  output logic                  busy
);

  // Issue stage
  logic            iss_v;
  logic [ID_W-1:0] iss_id;
  logic [3:0]      iss_op;
  logic [31:0]     iss_a;
  logic [31:0]     iss_b;

  // Response stage
  logic            rsp_v;
  logic [ID_W-1:0] rsp_id;
  logic [31:0]     rsp_data_q;
  logic            rsp_err_q;

  logic [ID_W-1:0] rr_ptr;

  logic               rsp_sel_rdy;
  logic               rsp_adv;
  logic               iss_adv;
  logic               found;
  logic               xfer;
  logic [NUM_REQ-1:0] gnt;
  logic [ID_W-1:0]    win;
  logic [ID_W-1:0]    nxt_ptr;
  logic [3:0]         sel_op;
  logic [31:0]        sel_a;
  logic [31:0]        sel_b;

  // Requester index visited at scan step k, starting at base and wrapping at NUM_REQ.
  function automatic int rr_off(input logic [ID_W-1:0] base, input int k);
    int s;
    s = int'(base) + k;
    if (s >= NUM_REQ) s = s - NUM_REQ;
    return s;
  endfunction

  // Decode the response owner without indexing by a (possibly wider) id register.
  always_comb begin
    rsp_sel_rdy = 1'b0;
    rsp_valid   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (rsp_id == ID_W'(i)) begin
        rsp_sel_rdy  = rsp_ready[i];
        rsp_valid[i] = rsp_v;
      end
    end
  end

  assign rsp_adv = !rsp_v || rsp_sel_rdy;
  assign iss_adv = !iss_v || rsp_adv;

  // Round-robin scan from rr_ptr; the first valid requester wins and its payload is muxed.
  always_comb begin
    gnt    = '0;
    win    = '0;
    found  = 1'b0;
    sel_op = '0;
    sel_a  = '0;
    sel_b  = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!found && req_valid[i] && (i == rr_off(rr_ptr, k))) begin
          found  = 1'b1;
          gnt[i] = 1'b1;
          win    = ID_W'(i);
          sel_op = req_op[4*i +: 4];
          sel_a  = req_a[32*i +: 32];
          sel_b  = req_b[32*i +: 32];
        end
      end
    end
  end

  // No handshake is offered while reset is held, so req_ready reads 0 during reset.
  assign req_ready = (iss_adv && rst_n) ? gnt : '0;
  assign xfer      = iss_adv && found;
  assign nxt_ptr   = (win == ID_W'(NUM_REQ - 1)) ? '0 : win + ID_W'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      iss_v  <= 1'b0;
      iss_id <= '0;
      iss_op <= '0;
      iss_a  <= '0;
      iss_b  <= '0;
      rr_ptr <= '0;
    end else if (iss_adv) begin
      iss_v <= xfer;
      if (xfer) begin
        iss_id <= win;
        iss_op <= sel_op;
        iss_a  <= sel_a;
        iss_b  <= sel_b;
        rr_ptr <= nxt_ptr;
      end
    end
  end

  // Capture the ALU result whenever the response slot can move; an empty issue
  // stage simply produces an empty response slot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_v      <= 1'b0;
      rsp_id     <= '0;
      rsp_data_q <= '0;
      rsp_err_q  <= 1'b0;
    end else if (rsp_adv) begin
      rsp_v      <= iss_v;
      rsp_id     <= iss_id;
      rsp_data_q <= alu_result;
      rsp_err_q  <= (iss_op >= 4'b1011);
    end
  end

  assign alu_op   = iss_v ? iss_op : '0;
  assign alu_a    = iss_v ? iss_a  : '0;
  assign alu_b    = iss_v ? iss_b  : '0;
  assign rsp_data = rsp_data_q;
  assign rsp_err  = rsp_err_q;
  assign busy     = iss_v || rsp_v;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Purpose: randomized and directed stimulus for alu_share_arbiter against a
//          transaction-level reference model (queue of in-flight operations).
// Latency/backpressure: inputs change at negedge, outputs compared 1ns later.
module tb_alu_share_arbiter;
  localparam int N  = 2;
  localparam int IW = 2;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_ready;
  logic [4*N-1:0]  req_op;
  logic [32*N-1:0] req_a;
  logic [32*N-1:0] req_b;
  logic [3:0]      alu_op;
  logic [31:0]     alu_a;
  logic [31:0]     alu_b;
  logic [31:0]     alu_result;
  logic [N-1:0]    rsp_valid;
  logic [N-1:0]    rsp_ready;
  logic [31:0]     rsp_data;
  logic            rsp_err;
  logic            busy;

  always #5 clk = ~clk;

  alu_share_arbiter #(.NUM_REQ(N), .ID_W(IW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_a(req_a), .req_b(req_b),
    .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b), .alu_result(alu_result),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_err(rsp_err), .busy(busy)
  );

  // Stand-in for the shared ALU; codes 4'b1011 and up return 0.
  function automatic logic [31:0] alu_f(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      4'd0:    return a + b;
      4'd1:    return a - b;
      4'd2:    return a & b;
      4'd3:    return a | b;
      4'd4:    return a ^ b;
      4'd5:    return a << b[4:0];
      4'd6:    return a >> b[4:0];
      4'd7:    return $signed(a) >>> b[4:0];
      4'd8:    return {31'b0, $signed(a) < $signed(b)};
      4'd9:    return {31'b0, a < b};
      4'd10:   return b;
      default: return 32'd0;
    endcase
  endfunction

  assign alu_result = alu_f(alu_op, alu_a, alu_b);

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  // Reference model: each accepted operation is a queue entry that is first
  // "on the ALU" (stage 1) and then "offered as a response" (stage 2).
  typedef struct {
    int          id;
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    int          stage;
  } txn_t;

  txn_t        fl[$];
  int          rr = 0;
  logic [N-1:0] exp_g;

  function automatic int find_stage(input int s);
    foreach (fl[i]) if (fl[i].stage == s) return i;
    return -1;
  endfunction

  function automatic logic [N-1:0] exp_ready();
    int s1, s2;
    bit room;
    logic [N-1:0] g;
    g  = '0;
    s1 = find_stage(1);
    s2 = find_stage(2);
    room = (s1 < 0) || (s2 < 0) || rsp_ready[fl[s2].id];
    if (room) begin
      for (int k = 0; k < N; k++) begin
        int w;
        w = (rr + k) % N;
        if (req_valid[w]) begin
          g[w] = 1'b1;
          break;
        end
      end
    end
    return g;
  endfunction

  task automatic check_outputs();
    int s1, s2;
    logic [N-1:0] ev;
    exp_g = exp_ready();
    chk("req_ready", 32'(req_ready), 32'(exp_g));
    s1 = find_stage(1);
    s2 = find_stage(2);
    if (s1 >= 0) begin
      chk("alu_op", 32'(alu_op), 32'(fl[s1].op));
      chk("alu_a", alu_a, fl[s1].a);
      chk("alu_b", alu_b, fl[s1].b);
    end else begin
      chk("alu_op_idle", 32'(alu_op), 32'd0);
      chk("alu_a_idle", alu_a, 32'd0);
      chk("alu_b_idle", alu_b, 32'd0);
    end
    ev = '0;
    if (s2 >= 0) ev[fl[s2].id] = 1'b1;
    chk("rsp_valid", 32'(rsp_valid), 32'(ev));
    if (s2 >= 0) begin
      chk("rsp_data", rsp_data, fl[s2].res);
      chk("rsp_err", 32'(rsp_err), 32'(fl[s2].op >= 4'b1011));
    end
    chk("busy", 32'(busy), 32'(fl.size() != 0));
  endtask

  task automatic model_edge();
    int s1, s2;
    txn_t t;
    s2 = find_stage(2);
    if (s2 >= 0 && rsp_ready[fl[s2].id]) fl.delete(s2);
    s1 = find_stage(1);
    if (s1 >= 0 && find_stage(2) < 0) fl[s1].stage = 2;
    for (int w = 0; w < N; w++) begin
      if (exp_g[w]) begin
        t.id    = w;
        t.op    = req_op[4*w +: 4];
        t.a     = req_a[32*w +: 32];
        t.b     = req_b[32*w +: 32];
        t.res   = alu_f(t.op, t.a, t.b);
        t.stage = 1;
        fl.push_back(t);
        rr = (w + 1) % N;
      end
    end
  endtask

  // Called at a negedge with inputs already driven.
  task automatic step();
    #1;
    check_outputs();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic set_req(input int i, input logic v, input logic [3:0] op,
                         input logic [31:0] a, input logic [31:0] b);
    req_valid[i]      = v;
    req_op[4*i +: 4]  = op;
    req_a[32*i +: 32] = a;
    req_b[32*i +: 32] = b;
  endtask

  task automatic rand_req(input int i, input logic v);
    logic [31:0] a, b;
    a = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : 32'($urandom);
    b = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : 32'($urandom);
    set_req(i, v, 4'($urandom_range(0, 15)), a, b);
  endtask

  initial begin
    rst_n     = 1'b0;
    req_valid = '0;
    req_op    = '0;
    req_a     = '0;
    req_b     = '0;
    rsp_ready = '0;

    // Reset values
    @(negedge clk);
    #1;
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_alu_op", 32'(alu_op), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_data", rsp_data, 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Single ADD from requester 0: 5 + 7
    rsp_ready = 2'b11;
    set_req(0, 1'b1, 4'b0000, 32'd5, 32'd7);
    step();
    req_valid = '0;
    step();
    chk("single_rsp_valid", 32'(rsp_valid), 32'd1);
    chk("single_rsp_data", rsp_data, 32'd12);
    step();
    step();

    // Round-robin with SUB on both requesters
    for (int c = 0; c < 8; c++) begin
      set_req(0, 1'b1, 4'b0001, $urandom, $urandom);
      set_req(1, 1'b1, 4'b0001, 32'd0, 32'd1);
      step();
    end
    req_valid = '0;
    step();
    step();

    // Backpressure: response held for 5 cycles, then drained
    rsp_ready = 2'b00;
    for (int c = 0; c < 9; c++) begin
      if (c == 5) rsp_ready = 2'b11;
      rand_req(0, 1'b1);
      rand_req(1, 1'b1);
      step();
    end
    req_valid = '0;
    step();
    step();

    // Unsupported opcode followed by a supported one
    set_req(0, 1'b1, 4'b1100, 32'd3, 32'd4);
    step();
    set_req(0, 1'b1, 4'b1010, 32'd0, 32'd9);
    step();
    req_valid = '0;
    chk("bad_op_err", 32'(rsp_err), 32'd1);
    chk("bad_op_data", rsp_data, 32'd0);
    step();
    chk("pass_b_data", rsp_data, 32'd9);
    chk("pass_b_err", 32'(rsp_err), 32'd0);
    step();

    // Randomized traffic and backpressure
    for (int c = 0; c < 400; c++) begin
      rand_req(0, 1'($urandom_range(0, 2) != 0));
      rand_req(1, 1'($urandom_range(0, 2) != 0));
      rsp_ready = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 3) != 0) rsp_ready = 2'b11;
      step();
    end
    req_valid = '0;
    rsp_ready = 2'b11;
    step();
    step();

    // Idle gaps: one request every third cycle
    for (int c = 0; c < 15; c++) begin
      rand_req(c % 2, 1'(c % 3 == 0));
      rand_req(1 - (c % 2), 1'b0);
      step();
    end

    // Reset with both stages full
    rsp_ready = 2'b00;
    for (int c = 0; c < 3; c++) begin
      rand_req(0, 1'b1);
      rand_req(1, 1'b1);
      step();
    end
    chk("prefill_busy", 32'(busy), 32'd1);
    #2;
    rst_n     = 1'b0;
    req_valid = '0;
    #1;
    chk("arst_req_ready", 32'(req_ready), 32'd0);
    chk("arst_alu_op", 32'(alu_op), 32'd0);
    chk("arst_alu_a", alu_a, 32'd0);
    chk("arst_alu_b", alu_b, 32'd0);
    chk("arst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("arst_rsp_data", rsp_data, 32'd0);
    chk("arst_rsp_err", 32'(rsp_err), 32'd0);
    chk("arst_busy", 32'(busy), 32'd0);
    fl.delete();
    rr = 0;
    @(negedge clk);
    rst_n     = 1'b1;
    rsp_ready = 2'b11;
    rand_req(0, 1'b1);
    rand_req(1, 1'b1);
    #1;
    chk("post_rst_grant", 32'(req_ready), 32'd1);
    @(negedge clk);
    // the first cycle after release is re-run through the model from a clean edge
    fl.delete();
    rr = 0;
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    for (int c = 0; c < 10; c++) begin
      rand_req(0, 1'b1);
      rand_req(1, 1'b1);
      step();
    end
    req_valid = '0;
    step();
    step();
    step();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/alu_share_arbiter.md
# alu_share_arbiter

Shares the single combinational ALU between up to four requesters, e.g. the execute stage and an address-generation or multi-cycle helper unit. It arbitrates round-robin and registers the winning operation into an issue stage that drives the ALU ports. It captures the ALU result into a response register that is returned to the winning requester with valid/ready backpressure. Throughput is one operation per cycle; latency is two cycles.

## Interface
- NUM_REQ, 2, number of requesters (2..4)
- ID_W, 2, width of internal requester index (must satisfy 2**ID_W >= NUM_REQ)
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- req_valid  in  NUM_REQ  per-requester request valid
- req_ready  out  NUM_REQ  per-requester accept (one-hot or zero)
- req_op  in  4*NUM_REQ  ALU opcode, requester i at [4i+3:4i]
- req_a  in  32*NUM_REQ  operand 1, requester i at [32i+31:32i]
- req_b  in  32*NUM_REQ  operand 2, requester i at [32i+31:32i]
- alu_op  out  4  to ALU ALU_op
- alu_a  out  32  to ALU alu_data1
- alu_b  out  32  to ALU alu_data2
- alu_result  in  32  from ALU ALU_result
- rsp_valid  out  NUM_REQ  response valid (one-hot or zero)
- rsp_ready  in  NUM_REQ  per-requester response accept
- rsp_data  out  32  result, shared by all requesters
- rsp_err  out  1  opcode was unsupported (4'b1011..4'b1111)
- busy  out  1  issue or response stage occupied

## Operation
- Stages:
  - issue register: iss_v, iss_id, iss_op, iss_a, iss_b. It drives alu_op, alu_a and alu_b directly; when iss_v=0 it drives 0.
  - response register: rsp_v, rsp_id, rsp_data, rsp_err.
- Advance conditions:
  - rsp_adv = !rsp_v | rsp_ready[rsp_id]
  - iss_adv = !iss_v | rsp_adv
- Arbitration: when iss_adv=1, grant the first requester with req_valid set, scanning from rr_ptr upward with wrap-around. req_ready[winner]=1; all other req_ready bits are 0. When iss_adv=0, all req_ready bits are 0.
- A transfer occurs when req_valid[i] & req_ready[i] at a clock edge. At that edge:
  - load the issue register;
  - set rr_ptr = winner+1, mod NUM_REQ.
- On an edge where iss_adv=1 and there is no transfer, iss_v is cleared.
- On an edge where rsp_adv=1:
  - rsp_v <= iss_v, rsp_id <= iss_id, rsp_data <= alu_result;
  - rsp_err <= (iss_op >= 4'b1011).
- rsp_valid[rsp_id] = rsp_v. rsp_data and rsp_err hold stable while rsp_v=1 and the response is not accepted.
- Opcodes are passed through unmodified; the ALU returns 0 for unsupported codes. rsp_err only flags these codes.
- req_ready depends combinationally on req_valid and internal state. Requesters must not make req_valid depend on req_ready.
- busy = iss_v | rsp_v.

## Timing
- Reset, asynchronous:
  - iss_v=0, rsp_v=0, rr_ptr=0, all data registers 0.
  - Outputs: req_ready=0 (until a valid request arrives), alu_op=0, alu_a=0, alu_b=0, rsp_valid=0, rsp_data=0, rsp_err=0, busy=0.
- Reset asserted mid-operation discards all in-flight operations. No response is produced for them.
- Latency:
  - transfer at edge k → operands on the ALU during cycle k+1;
  - rsp_valid high from cycle k+2 (just after edge k+1).
- Throughput: back-to-back transfers every cycle while the addressed rsp_ready is high.
- Backpressure:
  - rsp_ready low holds the response register;
  - the issue register can still fill once;
  - after that, req_ready stays 0 until the response is accepted.
- A response accepted at an edge while the issue stage is full and another request is transferred: all three moves happen at the same edge. No bubble is inserted.
- Arithmetic, widths and wrap-around are owned by the ALU. This block adds no logic on the data path beyond the registers.

## Test plan
- Single op: req 0 sends op=4'b0000, a=5, b=7 at edge k → rsp_valid=2'b01 in cycle k+2, rsp_data=12, rsp_err=0.
- Round-robin: both requesters hold req_valid continuously with SUB operations (a=0, b=1 on req 1):
  - grants go 0,1,0,1;
  - req 1 results are 32'hFFFF_FFFF;
  - one response per cycle once the pipeline is full.
- Backpressure: rsp_ready held 0 for 5 cycles with req_valid high:
  - rsp_data is stable;
  - exactly one further request is accepted, then req_ready=0;
  - releasing rsp_ready drains both results in order with no loss.
- Unsupported opcode: op=4'b1100, a=3, b=4 → rsp_data=0, rsp_err=1. The next op, 4'b1010 with b=9, returns 9 with rsp_err=0.
- Reset mid-flight: assert rst_n=0 with both stages full:
  - all outputs go to their reset values immediately (asynchronous);
  - after release, the first grant goes to requester 0 when both request.
- Idle gaps: requests spaced 3 cycles apart:
  - busy rises and falls with each operation;
  - alu_op, alu_a and alu_b are 0 while iss_v=0.
